// File: rtl/cpu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pipe_pkg
//   Shared definitions for the CPU inter-stage pipeline registers.
//   - Default width localparams for pipe_stage_reg.
//   - Bit indices of the control bundle and a packed struct that stages use
//     to pack/unpack it.
//   - Operation encoding for a single pipe_slot register.
// -----------------------------------------------------------------------------
package cpu_pipe_pkg;

    localparam int PC_W_DEF        = 32;
    localparam int CTRL_W_DEF      = 8;
    localparam int DATA_W_DEF      = 128;
    localparam int STALL_CNT_W_DEF = 16;

    // Control bundle bit positions
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_ISJUMP   = 4;

    // Packed view of the default-width control bundle; first member is MSB,
    // so the field order mirrors the bit indices above.
    typedef struct packed {
        logic [2:0] rsvd;
        logic       isjump;
        logic       memtoreg;
        logic       memwrite;
        logic       memread;
        logic       regwrite;
    } ctrl_t;

    // pipe_slot operations
    typedef enum logic [2:0] {
        SLOT_HOLD        = 3'd0, // keep contents
        SLOT_LOAD        = 3'd1, // capture a beat, mark valid
        SLOT_CLR_KEEP_PC = 3'd2, // invalidate, zero ctrl/data, keep pc
        SLOT_CLR_LOAD_PC = 3'd3, // invalidate, zero ctrl/data, load pc
        SLOT_CLR         = 3'd4  // zero everything
    } slot_op_e;

    function automatic ctrl_t ctrl_unpack(input logic [CTRL_W_DEF-1:0] v);
        return ctrl_t'(v);
    endfunction

    function automatic logic [CTRL_W_DEF-1:0] ctrl_pack(input ctrl_t c);
        return CTRL_W_DEF'(c);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
//   One valid + pc + ctrl + data register with load / clear-keep-pc /
//   clear-load-pc / clear operations. Used for the main slot and, when the
//   skid buffer is built, for the skid slot.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   op_i           operation for this edge (slot_op_e)
//   pc_i/ctrl_i/data_i   beat to capture (pc_i also used by CLR_LOAD_PC)
//   vld_o/pc_o/ctrl_o/data_o   registered slot contents
// -----------------------------------------------------------------------------
module pipe_slot
    import cpu_pipe_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  slot_op_e          op_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              vld_o,
    output logic [PC_W-1:0]   pc_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              vld_q,  vld_d;
    logic [PC_W-1:0]   pc_q,   pc_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        vld_d  = vld_q;
        pc_d   = pc_q;
        ctrl_d = ctrl_q;
        data_d = data_q;
        case (op_i)
            SLOT_LOAD: begin
                vld_d  = 1'b1;
                pc_d   = pc_i;
                ctrl_d = ctrl_i;
                data_d = data_i;
            end
            SLOT_CLR_KEEP_PC: begin
                vld_d  = 1'b0;
                ctrl_d = '0;
                data_d = '0;
            end
            SLOT_CLR_LOAD_PC: begin
                vld_d  = 1'b0;
                pc_d   = pc_i;
                ctrl_d = '0;
                data_d = '0;
            end
            SLOT_CLR: begin
                vld_d  = 1'b0;
                pc_d   = '0;
                ctrl_d = '0;
                data_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            pc_q   <= '0;
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            pc_q   <= pc_d;
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign pc_o   = pc_q;
    assign ctrl_o = ctrl_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Handshaked pipeline-stage register carrying pc, control bundle and an
//   opaque payload. Flush invalidates everything but keeps (or reloads) pc.
//   A saturating counter tracks cycles stalled by downstream.
// Build option:
//   PIPE_SKID_EN  adds a skid slot (capacity 2) and makes in_ready a pure
//                 register (~skid_full). Without it capacity is 1 and
//                 in_ready = ~out_valid | out_ready.
// Ports:
//   sys_clk, sys_rst               clock, synchronous active-high reset
//   in_valid/in_ready              upstream handshake
//   in_pc/in_ctrl/in_data          upstream beat
//   flush_i                        kill held and incoming beats this cycle
//   out_valid/out_ready            downstream handshake
//   out_pc/out_ctrl/out_data       main slot contents
//   stall_cnt                      saturating count of out_valid & ~out_ready
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int CTRL_W      = CTRL_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_W-1:0]        in_pc,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   flush_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic              main_vld;
    slot_op_e          main_op;
    logic [PC_W-1:0]   main_pc_src;
    logic [CTRL_W-1:0] main_ctrl_src;
    logic [DATA_W-1:0] main_data_src;

    logic accept, emit, stall;

    assign accept = in_valid & in_ready;
    assign emit   = main_vld & out_ready;
    assign stall  = main_vld & ~out_ready;

`ifdef PIPE_SKID_EN
    logic              skid_vld;
    slot_op_e          skid_op;
    logic [PC_W-1:0]   skid_pc;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // Registered ready: only the skid slot state decides it.
    assign in_ready = ~skid_vld;

    always_comb begin
        main_op       = SLOT_HOLD;
        skid_op       = SLOT_HOLD;
        main_pc_src   = in_pc;
        main_ctrl_src = in_ctrl;
        main_data_src = in_data;
        if (flush_i) begin
            main_op = in_valid ? SLOT_CLR_LOAD_PC : SLOT_CLR_KEEP_PC;
            skid_op = SLOT_CLR;
        end else if (emit && skid_vld) begin
            // in_ready is low here, so no input can be accepted this cycle
            main_op       = SLOT_LOAD;
            main_pc_src   = skid_pc;
            main_ctrl_src = skid_ctrl;
            main_data_src = skid_data;
            skid_op       = SLOT_CLR;
        end else if (accept && (!main_vld || emit)) begin
            main_op = SLOT_LOAD;
        end else if (accept) begin
            skid_op = SLOT_LOAD;
        end else if (emit) begin
            main_op = SLOT_CLR_KEEP_PC;
        end
    end

    pipe_slot #(
        .PC_W   (PC_W),
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i  (sys_clk),
        .rst_i  (sys_rst),
        .op_i   (skid_op),
        .pc_i   (in_pc),
        .ctrl_i (in_ctrl),
        .data_i (in_data),
        .vld_o  (skid_vld),
        .pc_o   (skid_pc),
        .ctrl_o (skid_ctrl),
        .data_o (skid_data)
    );
`else
    // Single slot: a new beat may replace the one leaving this cycle.
    assign in_ready = ~main_vld | out_ready;

    always_comb begin
        main_op       = SLOT_HOLD;
        main_pc_src   = in_pc;
        main_ctrl_src = in_ctrl;
        main_data_src = in_data;
        if (flush_i) begin
            main_op = in_valid ? SLOT_CLR_LOAD_PC : SLOT_CLR_KEEP_PC;
        end else if (accept) begin
            main_op = SLOT_LOAD;
        end else if (emit) begin
            main_op = SLOT_CLR_KEEP_PC;
        end
    end
`endif

    pipe_slot #(
        .PC_W   (PC_W),
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk_i  (sys_clk),
        .rst_i  (sys_rst),
        .op_i   (main_op),
        .pc_i   (main_pc_src),
        .ctrl_i (main_ctrl_src),
        .data_i (main_data_src),
        .vld_o  (main_vld),
        .pc_o   (out_pc),
        .ctrl_o (out_ctrl),
        .data_o (out_data)
    );

    assign out_valid = main_vld;

    // Stall counter: saturates at all-ones, untouched by flush.
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Reference model is a queue of held beats with a fixed capacity (1, or 2
//   with PIPE_SKID_EN). The driver predicts readiness, occupancy, visible pc
//   and the stall count; accepted beats go to a scoreboard queue that an
//   independent monitor pops whenever the DUT emits.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int PC_W   = 32;
    localparam int CTRL_W = 8;
    localparam int DATA_W = 128;
    localparam int SCW    = 4;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              flush_i = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [PC_W-1:0]   out_pc;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [SCW-1:0]    stall_cnt;

    pipe_stage_reg #(
        .PC_W        (PC_W),
        .CTRL_W      (CTRL_W),
        .DATA_W      (DATA_W),
        .STALL_CNT_W (SCW)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush_i   (flush_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t mq[$];      // model: beats currently held, head = visible
    beat_t exp_q[$];   // scoreboard: accepted beats awaiting emission
    int    sc = 0;     // model stall count
    logic [PC_W-1:0] last_pc = '0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs at the falling edge, check the state visible
    // before the coming rising edge, then advance the model across it.
    task automatic step(input logic iv, input logic [PC_W-1:0] pc,
                        input logic [CTRL_W-1:0] ct, input logic ordy,
                        input logic fl, input logic rst);
        beat_t b;
        logic  exp_rdy, acc, emt;
        @(negedge sys_clk);
        b.pc   = pc;
        b.ctrl = ct;
        b.data = {$urandom, $urandom, $urandom, $urandom};
        in_valid  = iv;
        in_pc     = pc;
        in_ctrl   = ct;
        in_data   = b.data;
        out_ready = ordy;
        flush_i   = fl;
        sys_rst   = rst;
        #1;
        exp_rdy = (CAP == 2) ? (mq.size() < 2) : (mq.size() == 0 || ordy);
        chk("out_valid", {127'b0, out_valid}, {127'b0, mq.size() > 0});
        chk("in_ready",  {127'b0, in_ready},  {127'b0, exp_rdy});
        chk("stall_cnt", DATA_W'(stall_cnt),  DATA_W'(sc));
        chk("out_pc",    DATA_W'(out_pc),     DATA_W'(last_pc));
        if (mq.size() == 0) begin
            chk("out_ctrl_idle", DATA_W'(out_ctrl), '0);
            chk("out_data_idle", out_data, '0);
        end
        if (rst) begin
            mq.delete();
            exp_q.delete();
            sc = 0;
            last_pc = '0;
        end else begin
            if (mq.size() > 0 && !ordy && sc < (1 << SCW) - 1) sc++;
            if (fl) begin
                mq.delete();
                exp_q.delete();
                if (iv) last_pc = pc;
            end else begin
                emt = (mq.size() > 0) && ordy;
                acc = iv && exp_rdy;
                if (emt) void'(mq.pop_front());
                if (acc) begin
                    mq.push_back(b);
                    exp_q.push_back(b);
                end
                if (mq.size() > 0) last_pc = mq[0].pc;
            end
        end
    endtask

    // Monitor: compare each emitted beat with the oldest accepted one.
    initial begin
        beat_t h;
        forever begin
            @(negedge sys_clk);
            #2;
            if (!sys_rst && !flush_i && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL emit_unexpected: got pc %0h expected no beat", out_pc);
                end else begin
                    h = exp_q.pop_front();
                    chk("emit_pc",   DATA_W'(out_pc),   DATA_W'(h.pc));
                    chk("emit_ctrl", DATA_W'(out_ctrl), DATA_W'(h.ctrl));
                    chk("emit_data", out_data, h.data);
                end
            end
        end
    end

    initial begin
        // reset
        step(0, '0, '0, 0, 0, 1);
        step(0, '0, '0, 0, 0, 1);
        step(0, '0, '0, 1, 0, 0);

        // stream with continuous out_ready
        step(1, 32'h100, 8'h01, 1, 0, 0);
        step(1, 32'h104, 8'h02, 1, 0, 0);
        step(1, 32'h108, 8'h03, 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);

        // back-pressure: fill main, offer a second beat, stall, release
        step(1, 32'h1A0, 8'h11, 0, 0, 0);
        step(1, 32'h200, 8'h05, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, '0, '0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 0, 0);

        // flush with slots full and a beat offered
        step(1, 32'h400, 8'h21, 0, 0, 0);
        step(1, 32'h404, 8'h22, 0, 0, 0);
        step(1, 32'h300, 8'h23, 0, 1, 0);
        step(0, '0, '0, 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);

        // flush with in_valid=0 keeps pc 0x1F0
        step(1, 32'h1F0, 8'h31, 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);
        step(0, 32'h777, '0, 1, 1, 0);
        step(0, '0, '0, 1, 0, 0);

        // stall counter saturation
        step(1, 32'h500, 8'h41, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, '0, '0, 0, 0, 0);
        step(0, '0, '0, 0, 0, 0);
        step(0, '0, '0, 1, 0, 0);

        // reset beats flush while stalled and full
        step(1, 32'h600, 8'h51, 0, 0, 0);
        step(1, 32'h604, 8'h52, 0, 0, 0);
        step(0, '0, '0, 0, 0, 0);
        step(1, 32'h555, 8'h53, 0, 1, 1);
        step(0, '0, '0, 1, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, $urandom, CTRL_W'($urandom),
                 ($urandom % 3) != 0, ($urandom % 25) == 0, ($urandom % 97) == 0);

        // drain and confirm nothing was lost
        for (int i = 0; i < 4; i++) step(0, '0, '0, 1, 0, 0);
        chk("scoreboard_empty", DATA_W'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
